quad_sample_ctrl: RTL and testbench

Sampling controller that sequences the dual-channel quadrature decoder for the PID loop. A programmable timer periodically snapshots the packed 32-bit decoder count and computes a signed per-channel delta (velocity) for each sample window. Samples are presented to the PID/CPU side over a valid/ready handshake. The block also runs the decoder zeroing sequence: reset pulse, resync settle, then re-baseline.

---
 rtl/quad_sample_ctrl.sv | 178 +++++++++++++++++
 tb/tb_quad_sample_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_sample_ctrl.sv
// rtl/quad_sample_ctrl.sv - periodic quadrature sampler with velocity deltas and decoder zeroing; optional QSC_TIMESTAMP_EN adds sample_ts
module quad_sample_ctrl #(
    parameter int PERIOD_W   = 24,
    parameter int ZERO_PULSE = 2,
    parameter int SETTLE     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] period,
    input  logic                zero_req,
    output logic                zero_busy,
    output logic                dec_rst,
    input  logic [31:0]         count_in,
    output logic                s_valid,
    input  logic                s_ready,
    output logic [15:0]         pos1,
    output logic [15:0]         pos2,
    output logic [15:0]         vel1,
    output logic [15:0]         vel2,
    output logic                overrun,
    input  logic                overrun_clr
`ifdef QSC_TIMESTAMP_EN
    ,
    output logic [31:0]         sample_ts
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_ZPULSE,
        ST_ZSETTLE
    } state_t;

    localparam int SEQ_W = 8;

    state_t              state;
    logic [PERIOD_W-1:0] timer;
    logic [SEQ_W-1:0]    seq_cnt;
    logic [15:0]         prev1;
    logic [15:0]         prev2;

    logic [15:0]         cur1;
    logic [15:0]         cur2;
    logic [PERIOD_W-1:0] last_cnt;
    logic                zero_start;
    logic                tick;

    assign cur1 = count_in[15:0];
    assign cur2 = count_in[31:16];

    // Periods below 2 behave as 2, so the terminal count never drops below 1.
    assign last_cnt   = (period < PERIOD_W'(2)) ? PERIOD_W'(1) : period - PERIOD_W'(1);
    assign zero_start = zero_req && (state == ST_IDLE || state == ST_RUN);
    // ">=" catches a period lowered below the running count; zero_req and enable drop both pre-empt a tick.
    assign tick       = (state == ST_RUN) && enable && !zero_req && (timer >= last_cnt);

    // Sequencer: sampling timer, zeroing pulse/settle, and the delta baseline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            timer     <= '0;
            seq_cnt   <= '0;
            prev1     <= 16'h8000;
            prev2     <= 16'h8000;
            dec_rst   <= 1'b0;
            zero_busy <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (zero_start) begin
                        state     <= ST_ZPULSE;
                        seq_cnt   <= '0;
                        dec_rst   <= 1'b1;
                        zero_busy <= 1'b1;
                        timer     <= '0;
                    end else if (enable) begin
                        state <= ST_RUN;
                        prev1 <= cur1;
                        prev2 <= cur2;
                        timer <= '0;
                    end
                end
                ST_RUN: begin
                    if (zero_start) begin
                        state     <= ST_ZPULSE;
                        seq_cnt   <= '0;
                        dec_rst   <= 1'b1;
                        zero_busy <= 1'b1;
                        timer     <= '0;
                    end else if (!enable) begin
                        state <= ST_IDLE;
                        timer <= '0;
                    end else if (tick) begin
                        timer <= '0;
                        prev1 <= cur1;
                        prev2 <= cur2;
                    end else begin
                        timer <= timer + PERIOD_W'(1);
                    end
                end
                ST_ZPULSE: begin
                    if (seq_cnt == SEQ_W'(ZERO_PULSE - 1)) begin
                        state   <= ST_ZSETTLE;
                        seq_cnt <= '0;
                        dec_rst <= 1'b0;
                    end else begin
                        seq_cnt <= seq_cnt + SEQ_W'(1);
                    end
                end
                ST_ZSETTLE: begin
                    if (seq_cnt == SEQ_W'(SETTLE - 1)) begin
                        state     <= enable ? ST_RUN : ST_IDLE;
                        seq_cnt   <= '0;
                        zero_busy <= 1'b0;
                        timer     <= '0;
                        prev1     <= cur1;
                        prev2     <= cur2;
                    end else begin
                        seq_cnt <= seq_cnt + SEQ_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Sample register and handshake; a tick always loads fresh data, even over an unread sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid <= 1'b0;
            pos1    <= '0;
            pos2    <= '0;
            vel1    <= '0;
            vel2    <= '0;
            overrun <= 1'b0;
        end else begin
            if (zero_start) begin
                s_valid <= 1'b0;
            end else if (tick) begin
                s_valid <= 1'b1;
                pos1    <= cur1;
                pos2    <= cur2;
                vel1    <= cur1 - prev1;
                vel2    <= cur2 - prev2;
            end else if (s_valid && s_ready) begin
                s_valid <= 1'b0;
            end

            if (tick && s_valid && !s_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef QSC_TIMESTAMP_EN
    logic [31:0] cycle_cnt;

    // Free-running cycle counter, latched into sample_ts alongside each sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
            sample_ts <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (tick) begin
                sample_ts <= cycle_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_quad_sample_ctrl.sv
// tb/tb_quad_sample_ctrl.sv - randomized and directed self-checking bench for quad_sample_ctrl
module tb_quad_sample_ctrl;

    localparam int PW = 24;
    localparam int ZP = 2;
    localparam int ST = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [PW-1:0] period = '0;
    logic          zero_req = 1'b0;
    logic          zero_busy;
    logic          dec_rst;
    logic [31:0]   count_in = 32'h8000_8000;
    logic          s_valid;
    logic          s_ready = 1'b0;
    logic [15:0]   pos1, pos2, vel1, vel2;
    logic          overrun;
    logic          overrun_clr = 1'b0;
`ifdef QSC_TIMESTAMP_EN
    logic [31:0]   sample_ts;
`endif

    quad_sample_ctrl #(.PERIOD_W(PW), .ZERO_PULSE(ZP), .SETTLE(ST)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .period(period),
        .zero_req(zero_req), .zero_busy(zero_busy), .dec_rst(dec_rst),
        .count_in(count_in), .s_valid(s_valid), .s_ready(s_ready),
        .pos1(pos1), .pos2(pos2), .vel1(vel1), .vel2(vel2),
        .overrun(overrun), .overrun_clr(overrun_clr)
`ifdef QSC_TIMESTAMP_EN
        , .sample_ts(sample_ts)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: abstract counters for the zeroing window and the sample window.
    bit          m_running;
    int          m_busy_left;
    int          m_timer;
    int          m_prev1, m_prev2;
    bit          m_sv, m_ov, m_last_tick;
    logic [15:0] m_pos1, m_pos2, m_vel1, m_vel2;
    logic [31:0] m_cyc, m_ts;

    task automatic model_reset();
        m_running = 0; m_busy_left = 0; m_timer = 0;
        m_prev1 = 32768; m_prev2 = 32768;
        m_sv = 0; m_ov = 0; m_last_tick = 0;
        m_pos1 = 0; m_pos2 = 0; m_vel1 = 0; m_vel2 = 0;
        m_cyc = 0; m_ts = 0;
    endtask

    task automatic model_step();
        int  c1, c2, eff;
        bit  tick, zs, ov_ev;
        c1 = int'(count_in[15:0]);
        c2 = int'(count_in[31:16]);
        tick = 0; zs = 0; ov_ev = 0;
        if (m_busy_left > 0) begin
            m_busy_left--;
            if (m_busy_left == 0) begin
                m_prev1 = c1; m_prev2 = c2; m_timer = 0; m_running = enable;
            end
        end else if (zero_req) begin
            m_busy_left = ZP + ST; zs = 1; m_timer = 0; m_running = 0;
        end else if (!m_running) begin
            if (enable) begin
                m_running = 1; m_prev1 = c1; m_prev2 = c2; m_timer = 0;
            end
        end else if (!enable) begin
            m_running = 0; m_timer = 0;
        end else begin
            eff = (period < 2) ? 2 : int'(period);
            if (m_timer >= eff - 1) begin
                tick = 1;
                m_timer = 0;
            end else begin
                m_timer++;
            end
        end
        if (tick) begin
            ov_ev  = m_sv && !s_ready;
            m_pos1 = 16'(c1);
            m_pos2 = 16'(c2);
            m_vel1 = 16'((c1 - m_prev1 + 65536) % 65536);
            m_vel2 = 16'((c2 - m_prev2 + 65536) % 65536);
            m_prev1 = c1; m_prev2 = c2;
            m_sv = 1;
            m_ts = m_cyc;
        end else if (zs) begin
            m_sv = 0;
        end else if (m_sv && s_ready) begin
            m_sv = 0;
        end
        if (ov_ev) m_ov = 1;
        else if (overrun_clr) m_ov = 0;
        m_cyc = m_cyc + 32'd1;
        m_last_tick = tick;
    endtask

    task automatic compare_all();
        check_val("s_valid", {31'd0, s_valid}, {31'd0, m_sv});
        check_val("overrun", {31'd0, overrun}, {31'd0, m_ov});
        check_val("zero_busy", {31'd0, zero_busy}, {31'd0, m_busy_left > 0});
        check_val("dec_rst", {31'd0, dec_rst}, {31'd0, m_busy_left > ST});
        check_val("pos1", {16'd0, pos1}, {16'd0, m_pos1});
        check_val("pos2", {16'd0, pos2}, {16'd0, m_pos2});
        check_val("vel1", {16'd0, vel1}, {16'd0, m_vel1});
        check_val("vel2", {16'd0, vel2}, {16'd0, m_vel2});
`ifdef QSC_TIMESTAMP_EN
        check_val("sample_ts", sample_ts, m_ts);
`endif
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic wait_tick(input string tag, output int n);
        bit seen;
        seen = 0;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            n++;
            if (m_last_tick) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check_val({tag, "_timeout"}, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        int n, n_dr, n_bz;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("rst_s_valid", {31'd0, s_valid}, 32'd0);
        check_val("rst_overrun", {31'd0, overrun}, 32'd0);
        check_val("rst_zero_busy", {31'd0, zero_busy}, 32'd0);
        check_val("rst_dec_rst", {31'd0, dec_rst}, 32'd0);
        check_val("rst_pos1", {16'd0, pos1}, 32'd0);
        check_val("rst_vel2", {16'd0, vel2}, 32'd0);
        rst_n = 1'b1;

        // Ramp ch1 by 3 per 10-cycle window.
        count_in = 32'h8000_8000; period = 10; s_ready = 1; enable = 1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (m_last_tick) begin
                check_val("ramp_vel1", {16'd0, vel1}, 32'd3);
                check_val("ramp_vel2", {16'd0, vel2}, 32'd0);
            end
            if ((i % 10) == 4) count_in[15:0] = count_in[15:0] + 16'd3;
        end

        // Wrap-around deltas and the minimum period.
        period = 0;
        count_in[15:0] = 16'hFFFE;
        wait_tick("wrap_a", n);
        wait_tick("p0_gap", n);
        check_val("p0_interval", n, 32'd2);
        count_in[15:0] = 16'h0001;
        wait_tick("wrap_b", n);
        check_val("wrap_fwd_vel1", {16'd0, vel1}, 32'h0003);
        count_in[15:0] = 16'hFFFE;
        period = 1;
        wait_tick("wrap_c", n);
        check_val("wrap_rev_vel1", {16'd0, vel1}, 32'hFFFD);
        wait_tick("p1_gap", n);
        check_val("p1_interval", n, 32'd2);

        // Overrun: two ticks without a consumer.
        period = 4; s_ready = 0;
        wait_tick("ovr_a", n);
        count_in[31:16] = 16'h1234;
        wait_tick("ovr_b", n);
        check_val("ovr_flag", {31'd0, overrun}, 32'd1);
        check_val("ovr_pos2", {16'd0, pos2}, 32'h1234);
        overrun_clr = 1;
        step();
        overrun_clr = 0;
        check_val("ovr_clr", {31'd0, overrun}, 32'd0);
        s_ready = 1;
        wait_tick("ovr_c", n);
        check_val("ovr_ready_tick", {31'd0, overrun}, 32'd0);

        // Zeroing with a pending sample and a repeated request while busy.
        period = 10; s_ready = 0;
        wait_tick("zero_pre", n);
        zero_req = 1;
        step();
        zero_req = 0;
        count_in = 32'h8000_8000;
        check_val("zero_s_valid", {31'd0, s_valid}, 32'd0);
        n_dr = 0; n_bz = 0;
        for (int i = 0; i < 20; i++) begin
            if (!zero_busy) break;
            if (dec_rst) n_dr++;
            n_bz++;
            zero_req = (i == 2);
            step();
        end
        zero_req = 0;
        check_val("zero_dec_rst_len", n_dr, ZP);
        check_val("zero_busy_len", n_bz, ZP + ST);
        count_in = 32'h8005_8007;
        s_ready = 1;
        wait_tick("zero_post", n);
        check_val("zero_base_vel1", {16'd0, vel1}, 32'd7);
        check_val("zero_base_vel2", {16'd0, vel2}, 32'd5);

        // Period lowered mid-count.
        enable = 0; step();
        enable = 1; period = 100; step();
        repeat (50) step();
        period = 5;
        wait_tick("plow_a", n);
        check_val("plow_first", n, 32'd1);
        wait_tick("plow_b", n);
        check_val("plow_next", n, 32'd5);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            enable      = ($urandom_range(0, 19) != 0);
            zero_req    = ($urandom_range(0, 59) == 0);
            s_ready     = $urandom_range(0, 1) == 1;
            overrun_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 39) == 0) period = PW'($urandom_range(0, 8));
            count_in[15:0]  = count_in[15:0] + 16'($urandom_range(0, 6)) - 16'd3;
            count_in[31:16] = count_in[31:16] + 16'($urandom_range(0, 6)) - 16'd3;
            step();
        end
        zero_req = 0; overrun_clr = 0;

        // Asynchronous reset while dec_rst is high.
        enable = 1; s_ready = 0; period = 2;
        repeat (6) step();
        zero_req = 1;
        step();
        zero_req = 0;
        check_val("ares_pre_dec_rst", {31'd0, dec_rst}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("ares_dec_rst", {31'd0, dec_rst}, 32'd0);
        check_val("ares_zero_busy", {31'd0, zero_busy}, 32'd0);
        check_val("ares_s_valid", {31'd0, s_valid}, 32'd0);
        check_val("ares_overrun", {31'd0, overrun}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        enable = 0;
        repeat (5) step();
        enable = 1; s_ready = 1;
        wait_tick("ares_resume", n);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
